// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis timing struct with 640x480@60 defaults,
// counter widths, sync-window helpers and RGB channel indices.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  // Control bits that travel through the latency-matching delay line.
  typedef struct packed {
    logic valid;
    logic hs;
    logic vs;
  } vga_ctl_t;

  localparam vga_axis_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_axis_t VGA480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int unsigned axis_total(input vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

  function automatic int unsigned sync_start(input vga_axis_t a);
    return a.active + a.fp;
  endfunction

  function automatic int unsigned sync_end(input vga_axis_t a);
    return a.active + a.fp + a.sync;
  endfunction

  localparam int VGA640_HW = $clog2(axis_total(VGA640_H));
  localparam int VGA480_VW = $clog2(axis_total(VGA480_V));

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam int MAX_LATENCY = 15;
  localparam int NUM_BARS    = 8;
  localparam int BAR_W       = $clog2(NUM_BARS);

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of parametrised width and depth; DEPTH=0 is a
// plain wire. Stages clear to zero on synchronous active-low reset.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with latency-matched sync/de/rgb outputs.
// Optional colour-bar test pattern is built only when VGA_TESTPAT_EN is defined.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = int'(VGA640_H.active),
  parameter int H_FP       = int'(VGA640_H.fp),
  parameter int H_SYNC     = int'(VGA640_H.sync),
  parameter int H_BP       = int'(VGA640_H.bp),
  parameter int V_ACTIVE   = int'(VGA480_V.active),
  parameter int V_FP       = int'(VGA480_V.fp),
  parameter int V_SYNC     = int'(VGA480_V.sync),
  parameter int V_BP       = int'(VGA480_V.bp),
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_BITS = 1,
  parameter int LATENCY    = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          pix_en,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]  req_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]  req_y,
  output logic                                          req_valid,
  input  logic [3*COLOR_BITS-1:0]                       pix_data,
  input  logic                                          test_en,
  output logic [3*COLOR_BITS-1:0]                       rgb,
  output logic                                          hsync,
  output logic                                          vsync,
  output logic                                          de,
  output logic                                          frame_start
);

  localparam vga_axis_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam int H_TOTAL = int'(axis_total(H_CFG));
  localparam int V_TOTAL = int'(axis_total(V_CFG));
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = 3 * COLOR_BITS;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(sync_start(H_CFG));
  localparam logic [HW-1:0] H_SE   = HW'(sync_end(H_CFG));
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(sync_start(V_CFG));
  localparam logic [VW-1:0] V_SE   = VW'(sync_end(V_CFG));

  localparam logic HS_ASSERT = 1'(HSYNC_POL);
  localparam logic VS_ASSERT = 1'(VSYNC_POL);

  if (LATENCY < 0 || LATENCY > MAX_LATENCY || COLOR_BITS < 1 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_param
    $error("vga_timing_pipe: LATENCY must be 0..15 and all timing parameters nonzero");
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [HW-1:0] req_x_q, req_x_d;
  logic [VW-1:0] req_y_q, req_y_d;
  vga_ctl_t      ctl_q, ctl_d;
  logic          frame_start_q, frame_start_d;
  vga_ctl_t      ctl_tap;

  logic [CW-1:0] rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [CW-1:0] src_data;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  // Request stage: coordinates and raw (active-high) sync registered together.
  always_comb begin
    req_x_d       = req_x_q;
    req_y_d       = req_y_q;
    ctl_d         = ctl_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      req_x_d       = h_q;
      req_y_d       = v_q;
      ctl_d.valid   = (h_q < H_ACT) && (v_q < V_ACT);
      ctl_d.hs      = (h_q >= H_SS) && (h_q < H_SE);
      ctl_d.vs      = (v_q >= V_SS) && (v_q < V_SE);
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (LATENCY)
  ) u_ctl_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   (ctl_q),
    .dout  (ctl_tap)
  );

`ifdef VGA_TESTPAT_EN
  logic [BAR_W-1:0] bar_q, bar_d;
  logic [BAR_W-1:0] bar_tap;
  logic [31:0]      bar_full;

  always_comb begin
    bar_full = (32'(h_q) * 32'(NUM_BARS)) / 32'(H_ACTIVE);
    bar_d    = bar_q;
    if (pix_en) begin
      bar_d = bar_full[BAR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_q <= '0;
    end else begin
      bar_q <= bar_d;
    end
  end

  vga_delay_line #(
    .WIDTH (BAR_W),
    .DEPTH (LATENCY)
  ) u_bar_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   (bar_q),
    .dout  (bar_tap)
  );

  always_comb begin
    src_data = pix_data;
    if (test_en) begin
      src_data = {{COLOR_BITS{bar_tap[CH_R]}},
                  {COLOR_BITS{bar_tap[CH_G]}},
                  {COLOR_BITS{bar_tap[CH_B]}}};
    end
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign src_data       = pix_data;
`endif

  always_comb begin
    rgb_d   = rgb_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      de_d    = ctl_tap.valid;
      rgb_d   = ctl_tap.valid ? src_data : '0;
      hsync_d = ctl_tap.hs ? HS_ASSERT : ~HS_ASSERT;
      vsync_d = ctl_tap.vs ? VS_ASSERT : ~VS_ASSERT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      ctl_q         <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ASSERT;
      vsync_q       <= ~VS_ASSERT;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      ctl_q         <= ctl_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign req_valid   = ctl_q.valid;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule
